// File: rtl/stream_fork2.sv
// ============================================================================
// stream_fork2 : 1-to-2 stream fork, each branch buffered by a 2-entry FIFO
// Revision     : 1.0
// ============================================================================
`default_nettype none

module stream_fork2_branch #(
    parameter int N = 18
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         room_next
);
    logic [1:0]   cnt_q, cnt_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [N-1:0] mem_q [2];
    logic [N-1:0] mem_d [2];
    logic         pop;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Lets the top register in_ready from next-state occupancy.
    assign room_next = (cnt_d != 2'd2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

module stream_fork2 #(
    parameter int N = 18
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out0_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [N-1:0] out1_data,
    output logic         out1_valid,
    input  logic         out1_ready
);
    logic in_ready_q, in_ready_d;
    logic accept;
    logic room0_next, room1_next;

    assign accept   = in_valid & in_ready_q;
    assign in_ready = in_ready_q;

    stream_fork2_branch #(.N(N)) u_branch0 (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept),
        .push_data (in_data),
        .out_ready (out0_ready),
        .out_valid (out0_valid),
        .out_data  (out0_data),
        .room_next (room0_next)
    );

    stream_fork2_branch #(.N(N)) u_branch1 (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept),
        .push_data (in_data),
        .out_ready (out1_ready),
        .out_valid (out1_valid),
        .out_data  (out1_data),
        .room_next (room1_next)
    );

    // Registered so that downstream readys never reach in_ready combinationally.
    always_comb begin
        in_ready_d = room0_next & room1_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_stream_fork2.sv
// Testbench for stream_fork2: directed scenarios plus randomized traffic
// checked against a queue-based model of the two branch streams.
`default_nettype none

module tb_stream_fork2;
    localparam int N = 18;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out0_data;
    logic         out0_valid;
    logic         out0_ready;
    logic [N-1:0] out1_data;
    logic         out1_valid;
    logic         out1_ready;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] q0 [$];
    logic [N-1:0] q1 [$];
    bit           m_rdy;
    bit           last_acc;

    always #5 clk = ~clk;

    stream_fork2 #(.N(N)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        if (q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
        if (q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
    endtask

    task automatic reset_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_v0"}, 32'(out0_valid), 32'd0);
        chk({tag, "_v1"}, 32'(out1_valid), 32'd0);
        chk({tag, "_d0"}, 32'(out0_data), 32'd0);
        chk({tag, "_d1"}, 32'(out1_data), 32'd0);
    endtask

    // One clock: model advances on the rising edge, DUT checked on the falling edge.
    task automatic step();
        bit acc, p0, p1;
        @(posedge clk);
        acc = in_valid && m_rdy;
        p0  = (q0.size() > 0) && out0_ready;
        p1  = (q1.size() > 0) && out1_ready;
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            q0.push_back(in_data);
            q1.push_back(in_data);
        end
        m_rdy    = (q0.size() < 2) && (q1.size() < 2);
        last_acc = acc;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        int sent;
        int cycles;
        logic [N-1:0] wa;

        rstn       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        m_rdy      = 1'b0;
        last_acc   = 1'b0;
        #1;
        reset_zero("por");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        step();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic fork with both consumers ready.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = N'(i);
            step();
        end
        chk("basic_d1_last", 32'(out1_data), 32'h3);
        drain();

        // Branch 1 stalled.
        out0_ready = 1'b1;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 18'h0AAAA;
        step();
        in_data = 18'h0BBBB;
        step();
        in_data = 18'h0CCCC;
        repeat (3) step();
        chk("stall_hold_d1", 32'(out1_data), 32'h0AAAA);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        out1_ready = 1'b1;
        last_acc   = 1'b0;
        for (int i = 0; i < 10 && !last_acc; i++) step();
        chk("stall_c_accepted", 32'(last_acc), 32'd1);
        drain();

        // Full boundary: two words, third held until both branches pop.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 18'h00011;
        step();
        in_data = 18'h00022;
        step();
        in_data = 18'h00033;
        repeat (3) step();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        chk("full_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("full_third_acc", 32'(last_acc), 32'd1);
        drain();

        // Simultaneous push and pop at occupancy 1.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 18'h1234A;
        step();
        in_data    = 18'h2B5C7;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pp_d0", 32'(out0_data), 32'h2B5C7);
        chk("pp_d1", 32'(out1_data), 32'h2B5C7);
        chk("pp_v0", 32'(out0_valid), 32'd1);
        chk("pp_v1", 32'(out1_valid), 32'd1);
        drain();

        // Randomized traffic.
        sent     = 0;
        cycles   = 0;
        in_valid = 1'b0;
        last_acc = 1'b0;
        while (sent < 1000 && cycles < 20000) begin
            if (last_acc || !in_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = N'($urandom);
            end
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            step();
            if (last_acc) sent++;
            cycles++;
        end
        chk("rand_sent", 32'(sent), 32'd1000);
        drain();

        // Reset mid-stream with two words buffered.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        wa         = 18'h3C3C3;
        in_data    = wa;
        step();
        in_data = 18'h15A5A;
        step();
        in_valid = 1'b0;
        chk("mid_buffered_d0", 32'(out0_data), 32'(wa));
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        reset_zero("mid");
        q0.delete();
        q1.delete();
        m_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("mid_rel_pre_edge", 32'(in_ready), 32'd0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        step();
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
